// File: rtl/id_forward_scoreboard_pkg.sv
// Shared pipeline definitions: slot indices, result-ready classes and the
// scoreboard entry layout used by the ID-stage forwarding unit.
package pipe_pkg;

  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  localparam int READY_ALU  = 0;
  localparam int READY_LOAD = 1;

  // Entry field widths; the forwarding unit's ADDR_W/DEPTH defaults track these.
  localparam int SB_ADDR_W = 5;
  localparam int SB_SLOT_W = 2;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] waddr;
    logic [SB_SLOT_W-1:0] ready_slot;
  } sb_entry_t;

endpackage

// File: rtl/id_forward_scoreboard_if.sv
// ID-stage operand/forwarding bundle between the decode datapath (master)
// and the forwarding scoreboard (slave).
interface id_forward_scoreboard_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int READ_PORTS = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1),
  parameter int RS_W       = $clog2(DEPTH)
);
  logic                         cpu_en;
  logic                         flush;
  logic [READ_PORTS-1:0]        rd_en;
  logic [READ_PORTS*ADDR_W-1:0] rd_addr;
  logic [READ_PORTS*DATA_W-1:0] rf_data;
  logic                         id_wen;
  logic [ADDR_W-1:0]            id_waddr;
  logic [RS_W-1:0]              id_ready_slot;
  logic [DEPTH*DATA_W-1:0]      stage_data;
  logic [READ_PORTS*SEL_W-1:0]  fwd_sel;
  logic [READ_PORTS*DATA_W-1:0] fwd_data;
  logic                         stall;
  logic [31:0]                  stall_count;

  modport master (
    output cpu_en, flush, rd_en, rd_addr, rf_data,
           id_wen, id_waddr, id_ready_slot, stage_data,
    input  fwd_sel, fwd_data, stall, stall_count
  );

  modport slave (
    input  cpu_en, flush, rd_en, rd_addr, rf_data,
           id_wen, id_waddr, id_ready_slot, stage_data,
    output fwd_sel, fwd_data, stall, stall_count
  );
endinterface

// File: rtl/id_forward_scoreboard_fwd_port_resolve.sv
// Resolves one ID source operand against the in-flight writers: youngest
// matching producer wins; a match whose result is not produced yet is not ready.
module fwd_port_resolve
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH-1:0]   entries_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  input  logic [DATA_W-1:0]       rf_data_i,
  input  logic [DEPTH*DATA_W-1:0] stage_data_i,
  output logic [SEL_W-1:0]        fwd_sel_o,
  output logic [DATA_W-1:0]       fwd_data_o,
  output logic                    ready_o
);

  logic              hit;
  logic              hit_ok;
  logic [SEL_W-1:0]  hit_sel;
  logic [DATA_W-1:0] hit_data;

  // Scan oldest to youngest so the last match seen is the youngest writer.
  always_comb begin
    hit      = 1'b0;
    hit_ok   = 1'b0;
    hit_sel  = '0;
    hit_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entries_i[k].valid && (entries_i[k].waddr == rd_addr_i) && (rd_addr_i != '0)) begin
        hit      = 1'b1;
        hit_ok   = (k >= int'(entries_i[k].ready_slot));
        hit_sel  = SEL_W'(k + 1);
        hit_data = stage_data_i[k*DATA_W +: DATA_W];
      end
    end
    ready_o    = !hit || hit_ok;
    fwd_sel_o  = (hit && hit_ok) ? hit_sel : '0;
    fwd_data_o = (hit && hit_ok) ? hit_data : rf_data_i;
  end

endmodule

// File: rtl/id_forward_scoreboard.sv
// Decode-stage forwarding/interlock unit: shift-register scoreboard of
// in-flight writers, per-port operand resolution, stall and stall counter.
module id_forward_scoreboard
  import pipe_pkg::*;
#(
  parameter int          DATA_W        = 32,
  parameter int          ADDR_W        = SB_ADDR_W,
  parameter int          DEPTH         = 3,
  parameter int          READ_PORTS    = 2,
  parameter logic [31:0] STALL_CNT_RST = '0
) (
  input logic                    clock,
  input logic                    reset,
  id_forward_scoreboard_if.slave sb_if
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0]        sb_q, sb_d;
  logic [31:0]                  stall_cnt_q, stall_cnt_d;
  logic [READ_PORTS-1:0]        port_ready;
  logic [READ_PORTS*SEL_W-1:0]  fwd_sel;
  logic [READ_PORTS*DATA_W-1:0] fwd_data;
  logic                         stall;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    fwd_port_resolve #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_resolve (
      .entries_i    (sb_q),
      .rd_addr_i    (sb_if.rd_addr[p*ADDR_W +: ADDR_W]),
      .rf_data_i    (sb_if.rf_data[p*DATA_W +: DATA_W]),
      .stage_data_i (sb_if.stage_data),
      .fwd_sel_o    (fwd_sel[p*SEL_W +: SEL_W]),
      .fwd_data_o   (fwd_data[p*DATA_W +: DATA_W]),
      .ready_o      (port_ready[p])
    );
  end

  assign stall             = (|(sb_if.rd_en & ~port_ready)) && !sb_if.flush;
  assign sb_if.stall       = stall;
  assign sb_if.fwd_sel     = fwd_sel;
  assign sb_if.fwd_data    = fwd_data;
  assign sb_if.stall_count = stall_cnt_q;

  always_comb begin
    sb_d        = sb_q;
    stall_cnt_d = stall_cnt_q;
    if (sb_if.cpu_en) begin
      if (sb_if.flush) begin
        for (int k = 0; k < DEPTH; k++) sb_d[k].valid = 1'b0;
      end else begin
        for (int k = DEPTH - 1; k > 0; k--) sb_d[k] = sb_q[k-1];
        if (stall) begin
          sb_d[0] = '0;
        end else begin
          sb_d[0].valid      = sb_if.id_wen && (sb_if.id_waddr != '0);
          sb_d[0].waddr      = sb_if.id_waddr;
          sb_d[0].ready_slot = sb_if.id_ready_slot;
        end
      end
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_q        <= '0;
      stall_cnt_q <= STALL_CNT_RST;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_forward_scoreboard.sv
// Directed + random bench for id_forward_scoreboard against a queue-based
// model of in-flight writers (index 0 = youngest).
module tb_id_forward_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en, flush, id_wen;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rf_data;
  logic [4:0]  id_waddr;
  logic [1:0]  id_rs;
  logic [95:0] stage_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit v;
    int a;
    int rs;
  } wr_t;

  wr_t         hist[$];
  logic [31:0] m_cnt, m_cnt_sat;
  logic [1:0]  m_sel[2];
  logic [31:0] m_data[2];
  logic        m_stall;

  always #5 clk = ~clk;

  id_forward_scoreboard_if if_main ();
  id_forward_scoreboard_if if_sat ();

  assign if_main.cpu_en        = cpu_en;
  assign if_main.flush         = flush;
  assign if_main.rd_en         = rd_en;
  assign if_main.rd_addr       = rd_addr;
  assign if_main.rf_data       = rf_data;
  assign if_main.id_wen        = id_wen;
  assign if_main.id_waddr      = id_waddr;
  assign if_main.id_ready_slot = id_rs;
  assign if_main.stage_data    = stage_data;
  assign if_sat.cpu_en         = cpu_en;
  assign if_sat.flush          = flush;
  assign if_sat.rd_en          = rd_en;
  assign if_sat.rd_addr        = rd_addr;
  assign if_sat.rf_data        = rf_data;
  assign if_sat.id_wen         = id_wen;
  assign if_sat.id_waddr       = id_waddr;
  assign if_sat.id_ready_slot  = id_rs;
  assign if_sat.stage_data     = stage_data;

  id_forward_scoreboard u_dut (
    .clock (clk),
    .reset (reset),
    .sb_if (if_main)
  );

  // Second copy starts its counter just below saturation.
  id_forward_scoreboard #(.STALL_CNT_RST(32'hFFFF_FF00)) u_dut_sat (
    .clock (clk),
    .reset (reset),
    .sb_if (if_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < 3; i++) hist.push_back('{1'b0, 0, 0});
    m_cnt     = 32'd0;
    m_cnt_sat = 32'hFFFF_FF00;
  endtask

  task automatic eval_model();
    logic nr;
    int   addr;
    m_stall = 1'b0;
    for (int p = 0; p < 2; p++) begin
      addr      = int'(rd_addr[p*5 +: 5]);
      m_sel[p]  = 2'd0;
      m_data[p] = rf_data[p*32 +: 32];
      nr        = 1'b0;
      if (addr != 0) begin
        for (int i = 0; i < hist.size(); i++) begin
          if (hist[i].v && hist[i].a == addr) begin
            if (i >= hist[i].rs) begin
              m_sel[p]  = 2'(i + 1);
              m_data[p] = stage_data[i*32 +: 32];
            end else begin
              nr = 1'b1;
            end
            break;
          end
        end
      end
      if (rd_en[p] && nr) m_stall = 1'b1;
    end
    if (flush) m_stall = 1'b0;
  endtask

  task automatic sample();
    rf_data    = {$urandom, $urandom};
    stage_data = {$urandom, $urandom, $urandom};
    @(negedge clk);
    eval_model();
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("fwd_sel[%0d]", p), 32'(if_main.fwd_sel[p*2 +: 2]), 32'(m_sel[p]));
      chk($sformatf("fwd_data[%0d]", p), if_main.fwd_data[p*32 +: 32], m_data[p]);
    end
    chk("stall", 32'(if_main.stall), 32'(m_stall));
    chk("stall_count", if_main.stall_count, m_cnt);
    chk("stall_count_sat", if_sat.stall_count, m_cnt_sat);
  endtask

  task automatic advance();
    if (reset) begin
      model_reset();
    end else if (cpu_en) begin
      if (flush) begin
        for (int i = 0; i < hist.size(); i++) hist[i].v = 1'b0;
      end else begin
        if (m_stall) hist.push_front('{1'b0, 0, 0});
        else hist.push_front('{(id_wen && id_waddr != 0), int'(id_waddr), int'(id_rs)});
        void'(hist.pop_back());
      end
      if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (m_stall && m_cnt_sat != 32'hFFFF_FFFF) m_cnt_sat++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic wen, input int waddr, input int rs,
                        input logic en0, input int a0, input logic en1, input int a1);
    id_wen   = wen;
    id_waddr = 5'(waddr);
    id_rs    = 2'(rs);
    rd_en    = {en1, en0};
    rd_addr  = {5'(a1), 5'(a0)};
  endtask

  initial begin
    reset  = 1'b1;
    cpu_en = 1'b1;
    flush  = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    rf_data    = '0;
    stage_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    set_id(0, 0, 0, 1, 5, 0, 0);
    sample();
    chk("rst_stall", 32'(if_main.stall), 32'd0);
    chk("rst_count", if_main.stall_count, 32'd0);
    advance();
    reset = 1'b0;
    sample();
    chk("r5_sel", 32'(if_main.fwd_sel[1:0]), 32'd0);
    chk("r5_data", if_main.fwd_data[31:0], rf_data[31:0]);
    advance();

    // ALU producer forwarded from EX then MEM
    set_id(1, 3, 0, 0, 0, 0, 0); sample(); advance();
    set_id(0, 0, 0, 1, 3, 0, 0); sample();
    chk("alu_ex_sel", 32'(if_main.fwd_sel[1:0]), 32'd1);
    chk("alu_ex_data", if_main.fwd_data[31:0], stage_data[31:0]);
    chk("alu_ex_stall", 32'(if_main.stall), 32'd0);
    advance();
    sample();
    chk("alu_mem_sel", 32'(if_main.fwd_sel[1:0]), 32'd2);
    advance();

    // Load-use: one stall, then forward from MEM
    set_id(1, 4, 1, 0, 0, 0, 0); sample(); advance();
    set_id(0, 0, 0, 0, 0, 1, 4); sample();
    chk("lu_stall", 32'(if_main.stall), 32'd1);
    advance();
    sample();
    chk("lu_stall2", 32'(if_main.stall), 32'd0);
    chk("lu_sel", 32'(if_main.fwd_sel[3:2]), 32'd2);
    chk("lu_data", if_main.fwd_data[63:32], stage_data[63:32]);
    chk("lu_count", if_main.stall_count, 32'd1);
    advance();

    // Younger ALU writer beats older load; r0 never forwards
    set_id(1, 7, 1, 0, 0, 0, 0); sample(); advance();
    set_id(1, 7, 0, 0, 0, 0, 0); sample(); advance();
    set_id(0, 0, 0, 1, 7, 0, 0); sample();
    chk("r7_sel", 32'(if_main.fwd_sel[1:0]), 32'd1);
    advance();
    set_id(1, 0, 0, 0, 0, 0, 0); sample(); advance();
    set_id(0, 0, 0, 1, 0, 1, 0); sample();
    chk("r0_sel", 32'(if_main.fwd_sel[1:0]), 32'd0);
    chk("r0_stall", 32'(if_main.stall), 32'd0);
    advance();

    // Flush kills the stall and empties the scoreboard
    set_id(1, 2, 1, 0, 0, 0, 0); sample(); advance();
    set_id(0, 0, 0, 1, 2, 0, 0); flush = 1'b1; sample();
    chk("flush_stall", 32'(if_main.stall), 32'd0);
    advance();
    flush = 1'b0; sample();
    chk("flush_sel", 32'(if_main.fwd_sel[1:0]), 32'd0);
    chk("flush_stall2", 32'(if_main.stall), 32'd0);
    advance();

    // Frozen pipeline holds the hazard and the counter
    set_id(1, 2, 1, 0, 0, 0, 0); sample(); advance();
    set_id(0, 0, 0, 1, 2, 0, 0);
    cpu_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("frz_stall", 32'(if_main.stall), 32'd1);
      chk("frz_count", if_main.stall_count, 32'd1);
      advance();
    end
    cpu_en = 1'b1;
    sample(); chk("unfrz_stall", 32'(if_main.stall), 32'd1); advance();
    sample();
    chk("unfrz_sel", 32'(if_main.fwd_sel[1:0]), 32'd2);
    chk("unfrz_count", if_main.stall_count, 32'd2);
    advance();

    // Load with unused consumer port
    set_id(1, 9, 1, 0, 0, 0, 0); sample(); advance();
    set_id(0, 0, 0, 0, 9, 0, 9); sample();
    chk("rden0_stall", 32'(if_main.stall), 32'd0);
    advance();

    // Reset while stalled
    set_id(1, 1, 1, 0, 0, 0, 0); sample(); advance();
    set_id(0, 0, 0, 1, 1, 0, 0); sample();
    chk("rst_mid_stall", 32'(if_main.stall), 32'd1);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    sample();
    chk("post_rst_stall", 32'(if_main.stall), 32'd0);
    chk("post_rst_sel", 32'(if_main.fwd_sel[1:0]), 32'd0);
    advance();

    // Back-to-back self-dependent loads: stall every other cycle
    for (int i = 0; i < 600; i++) begin
      set_id(1, 9, 1, 1, 9, 0, 0);
      sample();
      advance();
    end
    sample();
    chk("sat_count", if_sat.stall_count, 32'hFFFF_FFFF);
    advance();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cpu_en = ($urandom_range(0, 9) != 0);
      flush  = ($urandom_range(0, 19) == 0);
      set_id(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_forward_scoreboard.md
# id_forward_scoreboard

Parametrised forwarding and interlock unit for the decode stage. It generalises the fixed EX/MEM forward-select logic to DEPTH in-flight stages, READ_PORTS source operands and per-instruction result-ready latency. It keeps a shift-register scoreboard of in-flight register writers and resolves, for each ID operand, either register-file data or the youngest ready producer's result. When a needed producer is not ready yet, it raises `stall`. It sits beside the register file in ID and feeds the ALU A/B operand muxes and the branch comparator.

## Interface
- `DATA_W`, 32, operand/result width
- `ADDR_W`, 5, register address width; address 0 is hard-wired zero
- `DEPTH`, 3, in-flight stages tracked after ID (slot 0 = EX, 1 = MEM, 2 = WB)
- `READ_PORTS`, 2, ID source operands (rs, rt)
- `SEL_W`, $clog2(DEPTH+1), forward-select width
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `cpu_en` in 1: pipeline advance enable; low freezes all state
- `flush` in 1: invalidate every scoreboard entry
- `rd_en` in READ_PORTS: operand p is actually consumed by the ID instruction
- `rd_addr` in READ_PORTS*ADDR_W: source addresses, port p at [p*ADDR_W +: ADDR_W]
- `rf_data` in READ_PORTS*DATA_W: register-file read data per port
- `id_wen` in 1: ID instruction writes a register
- `id_waddr` in ADDR_W: its destination register
- `id_ready_slot` in $clog2(DEPTH): first slot whose `stage_data` holds its result (0 = ALU op, 1 = load)
- `stage_data` in DEPTH*DATA_W: current result of each slot, slot k at [k*DATA_W +: DATA_W]
- `fwd_sel` out READ_PORTS*SEL_W: 0 = register file, k+1 = slot k
- `fwd_data` out READ_PORTS*DATA_W: resolved operand per port
- `stall` out 1: hold PC and IF/ID; bubble into EX
- `stall_count` out 32: saturating count of stalled enabled cycles

## Operation
- Scoreboard entry: {valid, waddr, ready_slot}, DEPTH entries held as a shift register.
- Advance when `cpu_en`=1, in this order of precedence:
  - `flush`: all valid bits are cleared.
  - `stall`: slot 0 ← bubble (valid=0); slot k ← slot k-1.
  - Otherwise: slot 0 ← {id_wen && id_waddr≠0, id_waddr, id_ready_slot}; slot k ← slot k-1.
  - The entry leaving slot DEPTH-1 is discarded.
- Operand resolution per port p is combinational from the scoreboard and ID inputs:
  - A match is an entry with valid=1, waddr==rd_addr[p] and rd_addr[p]≠0.
  - Find the youngest match, i.e. the lowest slot index k.
  - If there is no match: `fwd_sel`=0 and `fwd_data`=`rf_data`.
  - If k ≥ ready_slot: `fwd_sel`=k+1 and `fwd_data`=`stage_data` slot k.
  - If k < ready_slot: the port is not ready.
- `stall` = OR over ports of (rd_en[p] && not ready[p]), gated with ~`flush`.
- `stall_count` increments on each cycle with `cpu_en` && `stall`, saturating at 0xFFFF_FFFF.

## Timing
- Reset values: all entries invalid, `stall`=0, `fwd_sel`=0, `fwd_data`=`rf_data`, `stall_count`=0.
- Resolution latency: 0 cycles. Scoreboard update latency: 1 cycle.
- Load-use: a load (ready_slot=1) followed immediately by a consumer gives exactly 1 stall cycle, then forwarding from slot 1.
- Generally, a consumer issued j cycles behind its producer stalls max(0, ready_slot - j + 1) cycles.
- Two producers of the same register: the younger one always wins, even if only the older one is ready. The consumer stalls instead of taking stale data.
- WB slot: `stage_data` slot DEPTH-1 is forwarded, so the register-file write-then-read ordering is irrelevant.
- `cpu_en`=0: entries hold and `stall_count` holds. Outputs still resolve combinationally.
- `reset` mid-stall: next cycle all entries are invalid and `stall`=0. No pending hazard survives reset.
- `flush` together with `stall`: flush wins and `stall` is forced to 0 that cycle.

## Structure
- Shared package `pipe_pkg` holds:
  - slot constants SLOT_EX=0, SLOT_MEM=1, SLOT_WB=2
  - ready classes READY_ALU=0, READY_LOAD=1
  - the `sb_entry_t` struct {valid, waddr, ready_slot}
- One sub-module `fwd_port_resolve` (priority match, select and ready over DEPTH entries) is instantiated READ_PORTS times from a generate loop. The top level holds the scoreboard register, the stall OR-reduction and the counter.

## Test plan
- Reset, then read r5 with no writers -> `fwd_sel`=0, `fwd_data`=`rf_data`, `stall`=0, `stall_count`=0.
- ALU write r3, then next instruction reads r3 -> `fwd_sel`=1 and `fwd_data`=`stage_data`[0] with `stall`=0. One cycle later, reading r3 gives `fwd_sel`=2.
- Load r4 (ready_slot=1), then consumer reads r4 -> `stall`=1 for 1 cycle, then `fwd_sel`=2 with no stall, and `stall_count`=1.
- Write r7 twice (load in slot 1, ALU in slot 0), then read r7 -> `fwd_sel`=1 from the ALU entry. Write to r0 followed by a read of r0 -> `fwd_sel`=0, `stall`=0.
- Load r2, consumer stalls, assert `flush` -> `stall`=0 that cycle and scoreboard empty next cycle. Same sequence with `cpu_en`=0 for 3 cycles -> `stall` stays 1, entries unchanged, `stall_count` unchanged.
- Load r9 with `rd_en`=0 on the consumer port -> `stall`=0. With `stall_count` preset near saturation via a long stall loop, the counter saturates at 0xFFFF_FFFF and does not wrap.
